// File: rtl/keypad_encoder.sv
// 4x3 matrix keypad scanner with two-flop row synchronizer, press/release debounce and strobe.
// Optional macro KEYPAD_SPECIAL_KEYS_EN: report * as 11 and # as 12 instead of "no key".
module keypad_encoder #(
  parameter int SCAN_CYCLES    = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [2:0] col,
  output logic [3:0] key,
  output logic       key_strobe
);

  localparam logic [3:0] KEY_NONE  = 4'd10;
  localparam logic [3:0] CYC_LAST  = 4'(SCAN_CYCLES - 1);
  localparam logic [2:0] DB_TARGET = 3'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {IDLE, PRESS_DB, PRESSED, RELEASE_DB} state_t;

  logic [3:0] r_row_s1, r_row_s2;
  logic [3:0] r_cyc;
  logic [1:0] r_colidx;
  logic [1:0] r_hits;
  logic [3:0] r_code;
  state_t     r_state, w_state_nx;
  logic [3:0] r_cand, w_cand_nx;
  logic [2:0] r_cnt, w_cnt_nx;
  logic [3:0] r_key, w_key_nx;
  logic       r_strobe, w_strobe_nx;

  logic       w_dwell_end, w_scan_done;
  logic [2:0] w_col_hits, w_prev_hits, w_total;
  logic [3:0] w_col_code, w_acc_code, w_result;
  logic [1:0] w_acc_hits;

  function automatic logic [2:0] low_count(input logic [3:0] rows);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) n = n + {2'b00, ~rows[i]};
    return n;
  endfunction

  // Code of the lowest-numbered low row in column c; only meaningful when exactly one row is low.
  function automatic logic [3:0] key_code(input logic [3:0] rows, input logic [1:0] c);
    logic [3:0] code;
    code = KEY_NONE;
    for (int r = 3; r >= 0; r--) begin
      if (!rows[r]) begin
        if (r == 3) begin
          case (c)
            2'd1:    code = 4'd0;
`ifdef KEYPAD_SPECIAL_KEYS_EN
            2'd0:    code = 4'd11;
            2'd2:    code = 4'd12;
`endif
            default: code = KEY_NONE;
          endcase
        end else begin
          code = 4'(r * 3) + {2'b00, c} + 4'd1;
        end
      end
    end
    return code;
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_row_s1 <= 4'hF;
      r_row_s2 <= 4'hF;
    end else begin
      r_row_s1 <= row;
      r_row_s2 <= r_row_s1;
    end
  end

  assign w_dwell_end = (r_cyc == CYC_LAST);
  assign w_scan_done = w_dwell_end && (r_colidx == 2'd2);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cyc    <= 4'd0;
      r_colidx <= 2'd0;
    end else if (w_dwell_end) begin
      r_cyc    <= 4'd0;
      r_colidx <= (r_colidx == 2'd2) ? 2'd0 : r_colidx + 2'd1;
    end else begin
      r_cyc <= r_cyc + 4'd1;
    end
  end

  always_comb begin
    case (r_colidx)
      2'd0:    col = 3'b110;
      2'd1:    col = 3'b101;
      default: col = 3'b011;
    endcase
  end

  // Per-scan accumulation: col0 starts fresh, hit count saturates at 2 (= multi).
  assign w_col_hits  = low_count(r_row_s2);
  assign w_col_code  = key_code(r_row_s2, r_colidx);
  assign w_prev_hits = (r_colidx == 2'd0) ? 3'd0 : {1'b0, r_hits};
  assign w_total     = w_prev_hits + w_col_hits;
  assign w_acc_hits  = (w_total >= 3'd2) ? 2'd2 : w_total[1:0];
  assign w_acc_code  = (w_col_hits == 3'd1) ? w_col_code :
                       ((r_colidx == 2'd0) ? KEY_NONE : r_code);
  assign w_result    = (w_total == 3'd1) ? w_acc_code : KEY_NONE;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_hits <= 2'd0;
      r_code <= KEY_NONE;
    end else if (w_dwell_end) begin
      r_hits <= w_acc_hits;
      r_code <= w_acc_code;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_cand   <= KEY_NONE;
      r_cnt    <= 3'd0;
      r_key    <= KEY_NONE;
      r_strobe <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_cand   <= w_cand_nx;
      r_cnt    <= w_cnt_nx;
      r_key    <= w_key_nx;
      r_strobe <= w_strobe_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_cand_nx   = r_cand;
    w_cnt_nx    = r_cnt;
    w_key_nx    = r_key;
    w_strobe_nx = 1'b0;
    if (w_scan_done) begin
      case (r_state)
        IDLE: begin
          if (w_result != KEY_NONE) begin
            w_cand_nx  = w_result;
            w_cnt_nx   = 3'd1;
            w_state_nx = PRESS_DB;
          end
        end
        PRESS_DB: begin
          if (w_result == KEY_NONE) begin
            w_cnt_nx   = 3'd0;
            w_key_nx   = KEY_NONE;
            w_state_nx = IDLE;
          end else if (w_result == r_cand) begin
            if (r_cnt >= DB_TARGET - 3'd1) begin
              w_cnt_nx    = DB_TARGET;
              w_key_nx    = r_cand;
              w_strobe_nx = 1'b1;
              w_state_nx  = PRESSED;
            end else begin
              w_cnt_nx = r_cnt + 3'd1;
            end
          end else begin
            w_cand_nx = w_result;
            w_cnt_nx  = 3'd1;
          end
        end
        PRESSED: begin
          if (w_result != r_key) begin
            w_cnt_nx   = 3'd1;
            w_state_nx = RELEASE_DB;
          end
        end
        RELEASE_DB: begin
          if (w_result == r_key) begin
            w_cnt_nx   = DB_TARGET;
            w_state_nx = PRESSED;
          end else if (r_cnt >= DB_TARGET - 3'd1) begin
            w_cnt_nx   = 3'd0;
            w_key_nx   = KEY_NONE;
            w_state_nx = IDLE;
          end else begin
            w_cnt_nx = r_cnt + 3'd1;
          end
        end
        default: w_state_nx = IDLE;
      endcase
    end
  end

  assign key        = r_key;
  assign key_strobe = r_strobe;

endmodule

// File: tb/tb_keypad_encoder.sv
// Scoreboard bench for keypad_encoder: a keypad model drives rows, a per-scan reference queues expected key events.
module tb_keypad_encoder;
  localparam int SC   = 4;
  localparam int DB   = 3;
  localparam int SCAN = 3 * SC;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] row;
  logic [2:0] col;
  logic [3:0] key;
  logic       key_strobe;

  always #5 clock = ~clock;

  keypad_encoder #(.SCAN_CYCLES(SC), .DEBOUNCE_SCANS(DB)) dut (
    .clock(clock), .reset(reset), .row(row),
    .col(col), .key(key), .key_strobe(key_strobe)
  );

  // Physical keypad: bit r*3+c pressed shorts row r to column c.
  logic [11:0] pressed = '0;
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (pressed[r*3+c] && !col[c]) row[r] = 1'b0;
  end

  int n_edge;
  always @(posedge clock or negedge reset)
    if (!reset) n_edge <= 0;
    else        n_edge <= n_edge + 1;

  typedef struct {int k; bit stb; int at;} ev_t;
  ev_t exp_q[$];
  ev_t mon_e;
  int  n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [2:0] exp_col(input int n);
    case ((n / SC) % 3)
      0:       return 3'b110;
      1:       return 3'b101;
      default: return 3'b011;
    endcase
  endfunction

  // Keypad-level meaning of one full scan with a given set of pressed keys.
  function automatic int scan_result(input logic [11:0] m);
    int p, r, c;
    if ($countones(m) != 1) return 10;
    p = 0;
    for (int i = 0; i < 12; i++) if (m[i]) p = i;
    r = p / 3;
    c = p % 3;
    if (r < 3) return r * 3 + c + 1;
    if (c == 1) return 0;
`ifdef KEYPAD_SPECIAL_KEYS_EN
    return (c == 0) ? 11 : 12;
`else
    return 10;
`endif
  endfunction

  int m_key = 10, s_code = 10, s_len = 0, miss = 0, scan_k = 0;

  task automatic model_step(input int res);
    int at;
    at = SCAN * (scan_k + 1);
    scan_k++;
    if (m_key == 10) begin
      if (res != 10 && res == s_code) s_len++;
      else begin
        s_code = res;
        s_len  = (res != 10) ? 1 : 0;
      end
      if (s_len == DB) begin
        m_key = res;
        exp_q.push_back('{res, 1'b1, at});
        s_len  = 0;
        s_code = 10;
        miss   = 0;
      end
    end else begin
      if (res == m_key) miss = 0;
      else              miss++;
      if (miss == DB) begin
        m_key = 10;
        exp_q.push_back('{10, 1'b0, at});
        miss = 0;
      end
    end
  endtask

  task automatic run_scans(input logic [11:0] m, input int cnt);
    repeat (cnt) begin
      pressed = m;
      model_step(scan_result(m));
      repeat (SCAN) @(negedge clock);
    end
  endtask

  function automatic logic [11:0] k2m(input int k);
    logic [11:0] m;
    m = '0;
    m[k] = 1'b1;
    return m;
  endfunction

  int prev_key = 10;
  always @(negedge clock) begin
    if (!reset) prev_key = 10;
    else begin
      check("col", int'(col), int'(exp_col(n_edge)));
      if (int'(key) != prev_key || key_strobe) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_event: key=%0d strobe=%0d at edge %0d, expected no change",
                   key, key_strobe, n_edge);
        end else begin
          mon_e = exp_q.pop_front();
          check("event_key", int'(key), mon_e.k);
          check("event_strobe", int'(key_strobe), int'(mon_e.stb));
          check("event_edge", n_edge, mon_e.at);
        end
      end
      prev_key = int'(key);
    end
  end

  initial begin
    int t, p1, p2;
    logic [11:0] m;
    repeat (3) @(negedge clock);
    check("reset_col", int'(col), 3'b110);
    check("reset_key", int'(key), 10);
    check("reset_strobe", int'(key_strobe), 0);
    reset = 1'b1;

    // '5' held 6 scans, then released
    run_scans(k2m(4), 6);
    check("held_5", int'(key), 5);
    run_scans('0, 4);
    // '8' with bounce
    run_scans(k2m(7), 1);
    run_scans('0, 1);
    run_scans(k2m(7), 3);
    run_scans('0, 3);
    // '1'+'2' together, then '9' replaced by '3'
    run_scans(k2m(0) | k2m(1), 5);
    run_scans('0, 1);
    run_scans(k2m(8), 4);
    run_scans(k2m(2), 7);
    run_scans(k2m(2) | k2m(8), 4);
    run_scans('0, 4);
    // '*', '#', '0'
    run_scans(k2m(9), 4);
    run_scans('0, 4);
    run_scans(k2m(11), 4);
    run_scans('0, 4);
    run_scans(k2m(10), 3);
    run_scans('0, 4);

    // '7' confirmed, then asynchronous reset mid-scan
    run_scans(k2m(6), 4);
    check("held_7", int'(key), 7);
    repeat (5) @(negedge clock);
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check("async_key", int'(key), 10);
    check("async_col", int'(col), 3'b110);
    check("async_strobe", int'(key_strobe), 0);
    check("pending_at_reset", exp_q.size(), 0);
    exp_q.delete();
    m_key = 10; s_code = 10; s_len = 0; miss = 0; scan_k = 0;
    pressed = '0;
    repeat (2) @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 60; i++) begin
      t = $urandom_range(0, 9);
      if (t < 6) begin
        run_scans(k2m($urandom_range(0, 11)), $urandom_range(1, 6));
      end else if (t < 8) begin
        run_scans('0, $urandom_range(1, 4));
      end else begin
        p1 = $urandom_range(0, 11);
        p2 = (p1 + $urandom_range(1, 11)) % 12;
        m  = k2m(p1) | k2m(p2);
        run_scans(m, $urandom_range(1, 3));
      end
    end
    run_scans('0, DB + 1);
    repeat (2) @(negedge clock);
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
